// File: rtl/conv_window_gen.sv
// Streaming SIZE x SIZE sliding-window generator feeding conv; buffers SIZE-1 lines.
// Optional macro CONV_WIN_SOF_EN adds a 'sof' input that restarts framing on accept.
module conv_window_gen #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic                                     clock,
  input  logic                                     nreset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WIDTH_BIT-1:0]                     pix_in,
`ifdef CONV_WIN_SOF_EN
  input  logic                                     sof,
`endif
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] winMatrix,
  output logic                                     frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_FILL = RW'(SIZE - 2);

  typedef enum logic {FILL, ACTIVE} state_e;
  typedef logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_t;

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d, col_e;
  logic [RW-1:0]        row_q, row_d, row_e;
  win_t                 win_q, win_d;
  logic [WIDTH_BIT-1:0] lb_q [SIZE-1][IMG_W];
  logic                 out_valid_q, out_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 acc, sof_e, last_col, last_pix, win_done;

`ifdef CONV_WIN_SOF_EN
  assign sof_e = sof;
`else
  assign sof_e = 1'b0;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;
  // A start-of-frame pixel is processed as coordinate (0,0) in the same cycle.
  assign col_e    = sof_e ? '0 : col_q;
  assign row_e    = sof_e ? '0 : row_q;
  assign last_col = (col_e == COL_LAST);
  assign last_pix = last_col && (row_e == ROW_LAST);
  assign win_done = (row_e >= ROW_WIN) && (col_e >= COL_WIN);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_valid_d  = out_ready ? 1'b0 : out_valid_q;
    frame_done_d = 1'b0;
    if (acc) begin
      col_d        = last_col ? '0 : col_e + CW'(1);
      row_d        = last_pix ? '0 : (last_col ? row_e + RW'(1) : row_e);
      frame_done_d = last_pix;
      if (win_done) out_valid_d = 1'b1;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE-1; j++)
          win_d[i][j] = win_q[i][j+1];
      for (int i = 0; i < SIZE-1; i++)
        win_d[i][SIZE-1] = lb_q[i][col_e];
      win_d[SIZE-1][SIZE-1] = pix_in;
      case (state_q)
        FILL:    if (last_col && row_e == ROW_FILL) state_d = ACTIVE;
        ACTIVE:  if (sof_e || last_pix) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < SIZE-1; k++)
        for (int c = 0; c < IMG_W; c++)
          lb_q[k][c] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      // Vertical shift of one column: oldest line drops out, newest pixel enters.
      if (acc) begin
        for (int k = 0; k < SIZE-2; k++)
          lb_q[k][col_e] <= lb_q[k+1][col_e];
        lb_q[SIZE-2][col_e] <= pix_in;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign winMatrix  = win_q;

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming sliding-window generator that sits upstream of the `conv` block and supplies its `SIZE`×`SIZE` input matrix. It accepts one raster-order pixel per handshake and buffers `SIZE-1` previous image lines. Whenever a complete, non-padded window exists, it presents that window with a valid/ready handshake. Each valid window is wired directly to `conv`'s matrix input, and `out_valid` drives `conv`'s `ena`.

## Interface
Parameters:
- `SIZE`, 3: window height and width; must match `conv`.
- `WIDTH_BIT`, 8: pixel width in bits.
- `IMG_W`, 8: image width in pixels; must be ≥ `SIZE`.
- `IMG_H`, 8: image height in lines; must be ≥ `SIZE`.

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `nreset`  in  1  reset, asynchronous and active-high; asserted when 1 despite the name.
- `in_valid`  in  1  `pix_in` is valid.
- `in_ready`  out  1  block can accept a pixel this cycle.
- `pix_in`  in  `WIDTH_BIT`  pixel, raster order (column fastest).
- `out_valid`  out  1  `winMatrix` holds a complete window.
- `out_ready`  in  1  consumer takes the window this cycle.
- `winMatrix`  out  `WIDTH_BIT` × [`SIZE`][`SIZE`]  window; `[i][j]` is row i (0 = oldest line), column j (0 = leftmost); `[SIZE-1][SIZE-1]` is the newest pixel.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Accept condition: `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational. There is a single output stage and no skid buffer.
- Counters: `col` runs 0..`IMG_W`-1 and `row` runs 0..`IMG_H`-1, each `$clog2` of the limit wide. Both advance only on accept. `col` wraps to 0 and increments `row`. At (`IMG_W`-1, `IMG_H`-1) both wrap to 0.
- Line buffers: `SIZE-1` arrays of `IMG_W` entries. On accept at column `col`, they shift vertically at index `col`:
  - line k takes line k+1;
  - the last line takes `pix_in`.
- Window register, on accept:
  - every row shifts left by one column;
  - the new column `[i][SIZE-1]` is loaded from line-buffer row i at `col` for i < `SIZE-1`;
  - `[SIZE-1][SIZE-1]` is loaded with `pix_in`.
- `winMatrix` is the window register itself. It is stable while `out_valid && !out_ready`, because no accept can occur then.
- Window-complete condition is `row >= SIZE-1 && col >= SIZE-1`, evaluated on the accepted pixel's coordinates. Windows that span a line wrap or the first `SIZE-1` lines are never emitted.
- States:
  - **FILL**: `row < SIZE-1`.
  - **ACTIVE**: at least `SIZE-1` lines are buffered.
  - FILL goes to ACTIVE on the accept of pixel (`IMG_W`-1, `SIZE`-2).
  - ACTIVE goes to FILL on the accept of the frame's last pixel.
- Windows per frame: (`IMG_W`-`SIZE`+1)·(`IMG_H`-`SIZE`+1). For the defaults this is 36.
- Arithmetic: no arithmetic on pixel data; values are stored and forwarded bit-exact.

## Timing
- Latency: `out_valid` rises the cycle after the accept edge of a window-completing pixel.
- `out_valid` next-state rules:
  - set to 1 on an accept whose pixel completes a window;
  - else cleared to 0 when `out_ready` is 1;
  - else held.
- Simultaneous `out_ready` and accept: the old window is consumed and the new window appears next cycle. Throughput is one window per cycle with no bubble.
- `frame_done` is registered and high exactly one cycle after the edge that accepts the last pixel.
- Reset values while `nreset` is 1 (take effect immediately):
  - `out_valid` = 0, `frame_done` = 0;
  - `col`, `row`, state = FILL;
  - `winMatrix` and all line buffers = 0;
  - `in_ready` therefore = 1.
- Reset mid-frame discards all buffered data. The first pixel accepted after release is (0,0).
- Back-to-back frames need no idle cycles. A new frame's windows never contain previous-frame pixels.

## Configuration
- `CONV_WIN_SOF_EN` defined:
  - adds input `sof` (1 bit), sampled only on accept;
  - when `sof` is 1, the accepted pixel is treated as (0,0): counters restart and state goes to FILL;
  - no `frame_done` pulse is generated for the truncated frame.
- `CONV_WIN_SOF_EN` undefined: no `sof` port; counters are free-running and framing is implicit from reset.

## Test plan
- **Continuous 8×8 frame**: defaults, pixel value = row·8+col, `in_valid`=1, `out_ready`=1.
  - 36 windows.
  - First window appears the cycle after pixel 18, with `[0][0]`=0, `[0][2]`=2, `[1][1]`=9, `[2][2]`=18.
  - Last window has `[2][2]`=63 and `[0][0]`=45.
  - `frame_done` high one cycle after pixel 63.
- **Backpressure**: hold `out_ready`=0 for 5 cycles at the first window.
  - `out_valid` stays 1, `winMatrix` is unchanged, `in_ready`=0.
  - After release, all 36 windows are identical to the first scenario.
- **Random input gaps**: random `in_valid` gaps plus random `out_ready`.
  - The window sequence is bit-identical to the first scenario; no duplicates, no drops.
- **Reset mid-frame**: assert `nreset` after 30 pixels.
  - `out_valid`=0 and `frame_done`=0 immediately.
  - A fresh frame's first window appears after its pixel 18 with `[0][0]`=0.
- **Two back-to-back frames**: second frame has pixel value = 100+row·8+col.
  - The second frame's first window has `[0][0]`=100 and `[2][2]`=118.
  - 72 windows total.
- **`CONV_WIN_SOF_EN` defined**: `sof`=1 on the 10th pixel of a frame.
  - No window is emitted until 18 further pixels.
  - The next window's `[0][0]` equals that `sof` pixel's value.
